source_alu: RTL and testbench
=============================

Name: source_alu

Overview:
- 5-bit, two's-complement, four-function arithmetic unit selected by a 2-bit opcode S.
- Operations: multiply, compare (max), add, and add-then-halve.
- Results are registered: F, Cout and Overflow update one clock after the operands/opcode are sampled.
- Sits as a leaf datapath block; its operands come from upstream control and are assumed stable around the clock edge.

Parameters:
- W, 5, operand/result width. All values below assume W=5; the logic must be written generically in W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- X  input  W  operand A, signed two's complement
- Y  input  W  operand B, signed two's complement
- S  input  2  operation select: 00 MUL, 01 CMP, 10 ADD, 11 ADDSHR
- F  output  W  registered result
- Cout  output  1  registered carry/auxiliary flag
- Overflow  output  1  registered signed-overflow flag

Behaviour:
- Reset: rst_n=0 asynchronously forces F=0, Cout=0, Overflow=0, held while rst_n is low. The first update occurs on the first rising clk after release.
- Each rising clk with rst_n=1 samples X, Y, S, computes combinationally, and registers all three outputs. Latency is exactly 1 cycle, throughput is 1 operation per cycle, and there is no handshake.
- S=00 MUL:
  - P = signed(X)*signed(Y), full 2W-bit product.
  - F = P[W-1:0].
  - Overflow=1 iff P lies outside [-2^(W-1), 2^(W-1)-1].
  - Cout=0.
- S=01 CMP:
  - F = signed maximum of X and Y; when X==Y, F = X.
  - Cout = 1 iff signed(X) > signed(Y), else 0.
  - Overflow=0.
- S=10 ADD:
  - F = (X+Y)[W-1:0].
  - Cout = carry out of bit W-1 (unsigned W-bit add).
  - Overflow=1 iff X and Y have the same sign and F's sign differs from it.
- S=11 ADDSHR:
  - Form the (W+1)-bit sign-extended sum T = sext(X)+sext(Y).
  - F = T[W:1], i.e. the arithmetic shift right by 1, floor of the average.
  - Cout = carry out of the unsigned W-bit addition X+Y.
  - Overflow=0 (the result always fits).
- Boundary cases:
  - Most-negative operands (10000) are handled by the same rules; 10000*10000 = +256 sets Overflow.
  - An opcode change takes effect on the next edge; there is no stale-mixing of operands between ops.
  - Reset assertion mid-stream clears outputs immediately, regardless of clk.

Decomposition:
- Shared package source_alu_pkg: width constant W_DEFAULT=5; opcode localparams OP_MUL=2'b00, OP_CMP=2'b01, OP_ADD=2'b10, OP_ADDSHR=2'b11.
- One sub-module source_alu_mul: a combinational W×W signed multiplier (shift-and-add array) producing the 2W-bit product.
- The top level holds the adder, comparator, result mux and output registers.

Test Plan:
- Reset: hold rst_n=0 with X=01010, Y=00110 and toggle clk -> F=00000, Cout=0, Overflow=0; release and clock once -> outputs reflect MUL.
- MUL: S=00 with X=01010, Y=00110 -> F=11100, Overflow=1, Cout=0. S=00 with X=11110, Y=11111 -> F=00010, Overflow=0, Cout=0.
- CMP: S=01 with X=01010, Y=11010 -> F=01010, Cout=1, Overflow=0. S=01 with X=11010, Y=01010 -> F=01010, Cout=0, Overflow=0.
- ADD: S=10 with X=00010, Y=11010 -> F=11100, Cout=0, Overflow=0. S=10 with X=01111, Y=01111 -> F=11110, Cout=0, Overflow=1.
- ADDSHR: S=11 with X=11010, Y=00010 -> F=11110, Cout=0, Overflow=0. S=11 with X=01010, Y=11010 -> F=00010, Cout=1, Overflow=0.
- Latency/async reset: change inputs mid-cycle -> outputs change only on the next rising clk. Pulse rst_n low between edges -> outputs are 0 immediately.

Source files
------------

// File: rtl/source_alu_pkg.sv
// Shared constants for the source_alu datapath: default width and opcode encodings.
package source_alu_pkg;

  localparam int unsigned W_DEFAULT = 5;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_CMP    = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_ADDSHR = 2'b11;

endpackage : source_alu_pkg

// File: rtl/source_alu_mul.sv
// Combinational W x W signed shift-and-add multiplier producing the full 2W-bit product.
module source_alu_mul #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] xe;
  logic [PW-1:0] acc;

  assign xe = {{W{x[W-1]}}, x};

  // The multiplier's sign bit carries negative weight, so its partial product is subtracted.
  always_comb begin
    acc = '0;
    for (int i = 0; i < int'(W) - 1; i++) begin
      if (y[i]) acc = acc + (xe << i);
    end
    if (y[W-1]) acc = acc - (xe << (W - 1));
  end

  assign p = acc;

endmodule : source_alu_mul

// File: rtl/source_alu.sv
// Four-function signed arithmetic unit (MUL, CMP max, ADD, ADDSHR) with registered outputs.
module source_alu
  import source_alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [1:0]   S,
  output logic [W-1:0] F,
  output logic         Cout,
  output logic         Overflow
);

  logic [2*W-1:0] prod;
  logic [W:0]     usum;
  logic [W:0]     ssum;
  logic           x_gt_y;
  logic           x_ge_y;
  logic           mul_ovf;
  logic           add_ovf;
  logic [W-1:0]   f_c;
  logic           cout_c;
  logic           ovf_c;

  source_alu_mul #(.W(W)) u_mul (
    .x (X),
    .y (Y),
    .p (prod)
  );

  assign usum   = {1'b0, X} + {1'b0, Y};
  assign ssum   = {X[W-1], X} + {Y[W-1], Y};
  assign x_gt_y = $signed(X) > $signed(Y);
  assign x_ge_y = $signed(X) >= $signed(Y);

  // Product fits in W signed bits only when its top W+1 bits are all copies of the sign.
  assign mul_ovf = ~((&prod[2*W-1:W-1]) | ~(|prod[2*W-1:W-1]));
  assign add_ovf = (X[W-1] == Y[W-1]) & (usum[W-1] != X[W-1]);

  // Result select
  always_comb begin
    f_c    = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    unique case (S)
      OP_MUL: begin
        f_c   = prod[W-1:0];
        ovf_c = mul_ovf;
      end
      OP_CMP: begin
        f_c    = x_ge_y ? X : Y;
        cout_c = x_gt_y;
      end
      OP_ADD: begin
        f_c    = usum[W-1:0];
        cout_c = usum[W];
        ovf_c  = add_ovf;
      end
      OP_ADDSHR: begin
        f_c    = ssum[W:1];
        cout_c = usum[W];
      end
      default: begin
        f_c    = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F        <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      F        <= f_c;
      Cout     <= cout_c;
      Overflow <= ovf_c;
    end
  end

endmodule : source_alu

// File: tb/tb_source_alu.sv
// Self-checking bench for source_alu: directed vector table plus reset/latency sequences.
module tb_source_alu;

  typedef struct {
    string      name;
    logic [1:0] s;
    logic [4:0] x;
    logic [4:0] y;
    logic [4:0] f;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] X;
  logic [4:0] Y;
  logic [1:0] S;
  logic [4:0] F;
  logic       Cout;
  logic       Overflow;

  int errors;
  int checks;

  vec_t vecs[$];

  source_alu #(.W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .X        (X),
    .Y        (Y),
    .S        (S),
    .F        (F),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] ef, input logic ec, input logic eo);
    checks++;
    if (F !== ef || Cout !== ec || Overflow !== eo) begin
      errors++;
      $display("FAIL %s: got F=%b Cout=%b Ovf=%b, expected F=%b Cout=%b Ovf=%b",
               name, F, Cout, Overflow, ef, ec, eo);
    end
  endtask

  task automatic add_vec(input string n, input logic [1:0] s, input logic [4:0] x, input logic [4:0] y,
                         input logic [4:0] f, input logic c, input logic o);
    vec_t v;
    v.name = n; v.s = s; v.x = x; v.y = y; v.f = f; v.cout = c; v.ovf = o;
    vecs.push_back(v);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    X      = 5'b01010;
    Y      = 5'b00110;
    S      = 2'b00;

    add_vec("mul_10x6",      2'b00, 5'b01010, 5'b00110, 5'b11100, 1'b0, 1'b1);
    add_vec("mul_m2xm1",     2'b00, 5'b11110, 5'b11111, 5'b00010, 1'b0, 1'b0);
    add_vec("mul_min_min",   2'b00, 5'b10000, 5'b10000, 5'b00000, 1'b0, 1'b1);
    add_vec("mul_min_x1",    2'b00, 5'b10000, 5'b00001, 5'b10000, 1'b0, 1'b0);
    add_vec("mul_15x15",     2'b00, 5'b01111, 5'b01111, 5'b00001, 1'b0, 1'b1);
    add_vec("cmp_pos_neg",   2'b01, 5'b01010, 5'b11010, 5'b01010, 1'b1, 1'b0);
    add_vec("cmp_neg_pos",   2'b01, 5'b11010, 5'b01010, 5'b01010, 1'b0, 1'b0);
    add_vec("cmp_equal",     2'b01, 5'b10011, 5'b10011, 5'b10011, 1'b0, 1'b0);
    add_vec("add_2_m6",      2'b10, 5'b00010, 5'b11010, 5'b11100, 1'b0, 1'b0);
    add_vec("add_15_15",     2'b10, 5'b01111, 5'b01111, 5'b11110, 1'b0, 1'b1);
    add_vec("add_min_min",   2'b10, 5'b10000, 5'b10000, 5'b00000, 1'b1, 1'b1);
    add_vec("shr_m6_2",      2'b11, 5'b11010, 5'b00010, 5'b11110, 1'b0, 1'b0);
    add_vec("shr_10_m6",     2'b11, 5'b01010, 5'b11010, 5'b00010, 1'b1, 1'b0);
    add_vec("shr_min_min",   2'b11, 5'b10000, 5'b10000, 5'b10000, 1'b1, 1'b0);
    add_vec("shr_15_15",     2'b11, 5'b01111, 5'b01111, 5'b01111, 1'b0, 1'b0);
    add_vec("shr_m1_0",      2'b11, 5'b11111, 5'b00000, 5'b11111, 1'b0, 1'b0);

    // Reset held across clock edges
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 5'b00000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_after_reset", 5'b11100, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      X = vecs[i].x;
      Y = vecs[i].y;
      S = vecs[i].s;
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].f, vecs[i].cout, vecs[i].ovf);
    end

    // Mid-cycle input change must not reach outputs before the next edge
    @(negedge clk);
    X = 5'b00010; Y = 5'b11010; S = 2'b10;
    @(posedge clk);
    #1 check("lat_first", 5'b11100, 1'b0, 1'b0);
    #2;
    X = 5'b01010; Y = 5'b11010; S = 2'b01;
    #1 check("lat_hold", 5'b11100, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("lat_update", 5'b01010, 1'b1, 1'b0);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", 5'b00000, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("async_reset_held", 5'b00000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_async_reset", 5'b01010, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_source_alu
